// File: rtl/alu_pkg.sv
// Purpose: shared constants for the iterative ALU units (FSM encoding, default width).
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_pkg;

    // Default operand/result width for the sequential divider.
    localparam int DIV_WIDTH_DEFAULT = 8;

    // Start/done FSM encoding shared by iterative units.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/div_trial_sub.sv
// Purpose: combinational ripple-borrow subtractor used for the divider's trial subtraction.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b (W bits) -> diff = a - b (W bits), borrow_out = 1 when b > a.
module div_trial_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow_out
);

    // borrow[i] is the borrow into bit i; the chain starts with no borrow-in.
    logic [W:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign diff[i]     = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign borrow_out = borrow[W];

endmodule

// File: rtl/div_seq_8.sv
// Purpose: sequential restoring unsigned divider, one quotient bit per cycle.
// Latency: done WIDTH+1 cycles after an accepted start (1 cycle for zero divisor with detect on).
// Backpressure: start accepted only in IDLE or DONE; ignored while busy.
// Ports: clk, rst (async, active-high); start/dividend/divisor in;
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero out (all registered).
// Option: define DIV_ZERO_DETECT_EN to flag a zero divisor and finish in one cycle;
//         otherwise div_by_zero is tied low and a zero divisor runs the full latency.
module div_seq_8 import alu_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             busy_q;
    logic             done_q;

    // Trial operand: partial remainder with the next dividend bit shifted in.
    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;

    assign trial_a = {r_q, q_q[WIDTH-1]};
    assign trial_b = {1'b0, d_q};

    div_trial_sub #(
        .W (WIDTH + 1)
    ) u_trial_sub (
        .a          (trial_a),
        .b          (trial_b),
        .diff       (trial_diff),
        .borrow_out (trial_borrow)
    );

    // The partial remainder stays below the divisor, so only the low WIDTH
    // bits of either the difference or the trial operand are ever kept.
    logic unused_trial_msbs;
    assign unused_trial_msbs = ^{trial_diff[WIDTH], trial_a[WIDTH]};

    logic accept;
    assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

`ifdef DIV_ZERO_DETECT_EN
    logic dbz_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
`ifdef DIV_ZERO_DETECT_EN
                        if (divisor == '0) begin
                            // Early exit: results are known without iterating.
                            d_q     <= divisor;
                            q_q     <= '1;
                            r_q     <= dividend;
                            dbz_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            dbz_q   <= 1'b0;
                            d_q     <= divisor;
                            q_q     <= dividend;
                            r_q     <= '0;
                            cnt_q   <= CNT_LAST;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end
`else
                        d_q     <= divisor;
                        q_q     <= dividend;
                        r_q     <= '0;
                        cnt_q   <= CNT_LAST;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    // Restore on borrow: keep the shifted remainder untouched.
                    r_q <= trial_borrow ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
                    q_q <= {q_q[WIDTH-2:0], ~trial_borrow};
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = q_q;
    assign remainder = r_q;

`ifdef DIV_ZERO_DETECT_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq_8.sv
// Purpose: randomized scoreboard bench for div_seq_8 against an arithmetic reference.
// Latency: expectations carry the cycle in which done must appear.
// Backpressure: starts issued while the unit is busy are expected to be ignored.
module tb_div_seq_8;

    localparam int W = 8;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    div_seq_8 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Rising-edge counter; sampled on falling edges.
    int ec = 0;
    always @(posedge clk) ec <= ec + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           acc;  // first cycle after the accepting edge
        int           at;   // edge count at which done must be visible
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   free_ec  = 0;     // unit accepts a start once ec >= free_ec

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Drive one cycle of inputs; the reference decides whether a start is taken.
    task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        start    = s;
        dividend = a;
        divisor  = b;
        if (s && ec >= free_ec) begin
            e.a   = a;
            e.b   = b;
            e.q   = (b == 0) ? {W{1'b1}} : W'(a / b);
            e.r   = (b == 0) ? a : W'(a % b);
            e.dbz = ZD && (b == 0);
            e.acc = ec + 1;
            e.at  = ec + 1 + ((ZD && b == 0) ? 0 : W);
            exp_q.push_back(e);
            free_ec = e.at;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, W'($urandom), W'($urandom));
    endtask

    // Monitor: busy window and done results compared against queued expectations.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            logic exp_busy;
            exp_busy = (exp_q.size() > 0) && (ec >= exp_q[0].acc) && (ec < exp_q[0].at);
            if (busy !== exp_busy) check("busy", busy, exp_busy);
            else n_pass += 0;
            if (busy === exp_busy) begin
                n_checks++;
                n_pass++;
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", done, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("quotient %0d/%0d", e.a, e.b), quotient, e.q);
                    check($sformatf("remainder %0d/%0d", e.a, e.b), remainder, e.r);
                    check($sformatf("div_by_zero %0d/%0d", e.a, e.b), div_by_zero, e.dbz);
                    check($sformatf("done_cycle %0d/%0d", e.a, e.b), ec, e.at);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_by_zero", div_by_zero, 1'b0);
        rst     = 1'b0;
        free_ec = ec;
        idle(2);

        // 100 / 7
        drive(1'b1, 8'd100, 8'd7);
        idle(10);

        // 255 / 1, then 5 / 9 started in the DONE cycle
        drive(1'b1, 8'd255, 8'd1);
        idle(8);
        drive(1'b1, 8'd5, 8'd9);
        idle(10);

        // 200 / 0
        drive(1'b1, 8'd200, 8'd0);
        idle(10);

        // 100 / 7 with an ignored 50 / 5 pulse in cycle 3
        drive(1'b1, 8'd100, 8'd7);
        idle(2);
        drive(1'b1, 8'd50, 8'd5);
        idle(8);

        // reset in cycle 4 of 100 / 7, then 9 / 3
        drive(1'b1, 8'd100, 8'd7);
        idle(3);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        exp_q.delete();
        @(negedge clk);
        rst     = 1'b0;
        free_ec = ec;
        drive(1'b1, 8'd9, 8'd3);
        idle(10);

        // Random traffic, including starts while busy and back-to-back starts.
        for (int n = 0; n < 5000; n++) begin
            logic         s;
            logic [W-1:0] a;
            logic [W-1:0] b;
            s = (ec >= free_ec) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 15) == 0) ? 8'hFF : W'($urandom);
            case ($urandom_range(0, 15))
                0:       b = 8'd0;
                1:       b = 8'd1;
                2:       b = 8'hFF;
                default: b = W'($urandom);
            endcase
            drive(s, a, b);
        end

        for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle(1);
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
